// File: rtl/decode_trace_queue_if.sv
// Record channels between the decoder, the trace queue and the instruction printer.
// The decoder side (dec_*) feeds records in; the printer side (prt_*) drains them.
interface decode_trace_queue_if #(
    parameter int INS_W = 256,
    parameter int PC_W  = 64,
    parameter int LEN_W = 4
);
    // Handshake: on each channel a record moves on a rising clk edge where valid and
    // ready are both 1. A source holding valid keeps its payload stable until that edge.
    // The queue's dec_ready never depends combinationally on prt_ready.
    logic             dec_valid;
    logic             dec_ready;
    logic [INS_W-1:0] dec_ins;
    logic [PC_W-1:0]  dec_pc;
    logic [LEN_W-1:0] dec_len;

    logic             prt_valid;
    logic             prt_ready;
    logic [INS_W-1:0] prt_ins;
    logic [PC_W-1:0]  prt_pc;
    logic [LEN_W-1:0] prt_len;
    logic [15:0]      prt_seq;

    // Environment view: drives decoder records and printer ready.
    modport master (
        output dec_valid, dec_ins, dec_pc, dec_len, prt_ready,
        input  dec_ready, prt_valid, prt_ins, prt_pc, prt_len, prt_seq
    );

    // Queue view.
    modport slave (
        input  dec_valid, dec_ins, dec_pc, dec_len, prt_ready,
        output dec_ready, prt_valid, prt_ins, prt_pc, prt_len, prt_seq
    );
endinterface

// File: rtl/decode_trace_queue.sv
// Elastic record buffer between the decoder and the instruction printer.
// Each accepted record is tagged with a 16-bit sequence number so that records
// dropped on overflow (STALL_ON_FULL=0) show up as gaps at the printer.
module decode_trace_queue #(
    parameter int DEPTH         = 8,
    parameter int INS_W         = 256,
    parameter int PC_W          = 64,
    parameter int LEN_W         = 4,
    parameter bit STALL_ON_FULL = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    flush,
    decode_trace_queue_if.slave     bus,
    output logic [$clog2(DEPTH):0]  count,
    output logic [15:0]             drop_cnt,
    output logic                    overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic [15:0]      seq_q;
    logic             live;
    logic             full;
    logic             empty;
    logic             accept;
    logic             push;
    logic             pop;
    logic             drop;

    logic [INS_W-1:0] mem_ins [DEPTH];
    logic [PC_W-1:0]  mem_pc  [DEPTH];
    logic [LEN_W-1:0] mem_len [DEPTH];
    logic [15:0]      mem_seq [DEPTH];

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
    assign count  = wr_ptr - rd_ptr;

    // live holds dec_ready low during reset and until the first edge after release.
    assign bus.dec_ready = live && (!full || !STALL_ON_FULL);
    assign bus.prt_valid = !empty;

    // A flush discards the same-cycle push and pop; an accepted record still burns a seq value.
    assign accept = bus.dec_valid && bus.dec_ready;
    assign push   = accept && !full && !flush;
    assign drop   = accept && full && !flush;
    assign pop    = bus.prt_valid && bus.prt_ready && !flush;

    // Head entry is presented only while valid, so every prt_* output reads 0 when empty.
    assign bus.prt_ins = bus.prt_valid ? mem_ins[rd_idx] : '0;
    assign bus.prt_pc  = bus.prt_valid ? mem_pc[rd_idx]  : '0;
    assign bus.prt_len = bus.prt_valid ? mem_len[rd_idx] : '0;
    assign bus.prt_seq = bus.prt_valid ? mem_seq[rd_idx] : '0;

    // Pointer, sequence counter and ready-enable update; flush collapses the queue.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            seq_q  <= '0;
            live   <= 1'b0;
        end else begin
            live <= 1'b1;
            if (accept) begin
                seq_q <= seq_q + 16'd1;
            end
            if (flush) begin
                rd_ptr <= wr_ptr;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
            end
        end
    end

    // Overflow bookkeeping: saturating drop counter and sticky flag, untouched by flush.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else if (drop) begin
            if (drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
            overflow <= 1'b1;
        end
    end

    // Record storage; write-only on push, contents irrelevant until the slot is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_ins[wr_idx] <= bus.dec_ins;
            mem_pc[wr_idx]  <= bus.dec_pc;
            mem_len[wr_idx] <= bus.dec_len;
            mem_seq[wr_idx] <= seq_q;
        end
    end
endmodule
